// File: rtl/ms_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ms_io_pkg
//  Purpose  : Shared definitions for IO-space responders: register offsets
//             within a peripheral window, STAT/CTRL bit positions, and a
//             helper that turns a transfer size (bytes) into a byte-lane mask.
//  Revision : 1.0  initial release
// ============================================================================
package ms_io_pkg;

    // Register offsets relative to the peripheral base address.
    localparam logic [4:0] CIoRegData = 5'h00;
    localparam logic [4:0] CIoRegStat = 5'h08;
    localparam logic [4:0] CIoRegCtrl = 5'h10;

    // STAT bit positions.
    localparam int CStatEmpty   = 0;
    localparam int CStatFull    = 1;
    localparam int CStatOvf     = 2;
    localparam int CStatUnf     = 3;
    localparam int CStatFillLsb = 8;

    // CTRL bit positions.
    localparam int CCtrlIrqEn = 0;
    localparam int CCtrlFlush = 1;

    // Byte-lane mask for a transfer of i_size bytes (0 = no lanes, >=8 = all).
    function automatic logic [63:0] f_size_mask(input logic [3:0] i_size);
        logic [63:0] w_mask;
        if (i_size == 4'd0) begin
            w_mask = '0;
        end else if (i_size >= 4'd8) begin
            w_mask = '1;
        end else begin
            w_mask = (64'd1 << {i_size[2:0], 3'b000}) - 64'd1;
        end
        return w_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ms_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ms_sync_fifo
//  Purpose  : Single-clock FIFO with push, pop and flush. A pop on a full
//             FIFO frees the slot a same-cycle push needs; flush overrides
//             both push and pop.
//  Ports    : clk/rst_n   clock, async active-low reset
//             i_en        clock enable, all state holds when 0
//             i_push/i_data, i_pop, i_flush   operations
//             o_head      word at the read pointer
//             o_full/o_empty/o_fill           occupancy
//             o_empty_nxt occupancy after the current edge is empty
//             o_drop      push rejected because the FIFO is full
//  Revision : 1.0  initial release
// ============================================================================
module ms_sync_fifo #(
    parameter int CDepth = 8,
    parameter int CDataW = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_en,
    input  logic                      i_push,
    input  logic [CDataW-1:0]         i_data,
    input  logic                      i_pop,
    input  logic                      i_flush,
    output logic [CDataW-1:0]         o_head,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(CDepth):0]   o_fill,
    output logic                      o_empty_nxt,
    output logic                      o_drop
);

    localparam int             CAw      = $clog2(CDepth);
    localparam logic [CAw-1:0] CPtrOne  = 1;
    localparam logic [CAw:0]   CCntOne  = 1;
    localparam logic [CAw:0]   CCntFull = (CAw + 1)'(CDepth);

    logic [CDataW-1:0] r_mem [CDepth];
    logic [CAw-1:0]    r_wptr;
    logic [CAw-1:0]    r_rptr;
    logic [CAw:0]      r_cnt;
    logic [CAw:0]      w_cnt_nxt;
    logic              w_pop;
    logic              w_push;
    logic              w_flush;

    assign o_full  = (r_cnt == CCntFull);
    assign o_empty = (r_cnt == '0);
    assign o_fill  = r_cnt;
    assign o_head  = r_mem[r_rptr];

    assign w_flush = i_en & i_flush;
    assign w_pop   = i_en & i_pop & ~o_empty & ~i_flush;
    assign w_push  = i_en & i_push & ~i_flush & (~o_full | w_pop);
    assign o_drop  = i_en & i_push & ~i_flush & o_full & ~w_pop;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_flush) begin
            w_cnt_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + CCntOne;
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - CCntOne;
        end
    end

    assign o_empty_nxt = (w_cnt_nxt == '0);

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + CPtrOne;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + CPtrOne;
            end
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ms_io_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : ms_io_mailbox
//  Purpose  : IO-space responder implementing an inbound mailbox. Local
//             hardware pushes words into a FIFO that the CPU pops through
//             DATA; CPU writes to DATA leave as a one-cycle outbound strobe.
//  Ports    : AClkH/AResetHN/AClkHEn   clock, async active-low reset, enable
//             AIoSpace*                IO-space bus (Miso/Busy/Srq are ORed
//                                      with other responders, so idle = 0)
//             ALclData/ALclWrEn/ALclFull  local push side
//             ATxData/ATxStrobe        outbound word and strobe
//  Revision : 1.0  initial release
// ============================================================================
module ms_io_mailbox
    import ms_io_pkg::*;
#(
    parameter logic [15:0] CBaseAddr = 16'h0100,
    parameter int          CDepth    = 8,
    parameter int          CDataW    = 32,
    parameter int          CWaitCnt  = 2
) (
    input  logic              AClkH,
    input  logic              AResetHN,
    input  logic              AClkHEn,
    input  logic [15:0]       AIoSpaceAddr,
    input  logic [63:0]       AIoSpaceMosi,
    output logic [63:0]       AIoSpaceMiso,
    input  logic [3:0]        AIoSpaceWrSize,
    input  logic [3:0]        AIoSpaceRdSize,
    output logic              AIoSpaceBusy,
    output logic              AIoSpaceSrq,
    input  logic [CDataW-1:0] ALclData,
    input  logic              ALclWrEn,
    output logic              ALclFull,
    output logic [CDataW-1:0] ATxData,
    output logic              ATxStrobe
);

    localparam int                CFillW   = $clog2(CDepth) + 1;
    localparam int                CWaitW   = (CWaitCnt > 0) ? $clog2(CWaitCnt + 1) : 1;
    localparam logic [CWaitW-1:0] CWaitEnd = CWaitW'(CWaitCnt);
    localparam logic [CWaitW-1:0] CWaitOne = 1;

    // Address decode and handshake
    logic [15:0]       w_off;
    logic              w_sel;
    logic              w_req;
    logic              w_is_data;
    logic              w_is_stat;
    logic              w_is_ctrl;
    logic              w_busy;
    logic              w_done;
    logic              w_rd;
    logic              w_wr;
    logic [63:0]       w_wdata;
    logic [63:0]       w_rdata;
    logic              w_pop_req;
    logic              w_flush;
    logic              w_unused;

    // FIFO interface
    logic [CDataW-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic [CFillW-1:0] w_fill;
    logic [7:0]        w_fill8;
    logic              w_empty_nxt;
    logic              w_drop;

    // State
    logic [CWaitW-1:0] r_wait;
    logic              r_irq_en;
    logic              r_ovf;
    logic              r_unf;
    logic [CDataW-1:0] r_tx_data;
    logic              r_tx_strobe;
    logic              r_srq;

    // Unsigned wrap-around subtraction makes the window test a single compare.
    assign w_off     = AIoSpaceAddr - CBaseAddr;
    assign w_sel     = (w_off < 16'h0018) && (w_off[2:0] == 3'b000);
    assign w_req     = w_sel && ((AIoSpaceWrSize != 4'd0) || (AIoSpaceRdSize != 4'd0));
    assign w_is_data = (w_off[4:0] == CIoRegData);
    assign w_is_stat = (w_off[4:0] == CIoRegStat);
    assign w_is_ctrl = (w_off[4:0] == CIoRegCtrl);

    assign w_busy = w_req && w_is_data && (r_wait != CWaitEnd);
    assign w_done = w_req && !w_busy;
    assign w_rd   = w_done && (AIoSpaceRdSize != 4'd0);
    assign w_wr   = w_done && (AIoSpaceWrSize != 4'd0);

    assign w_wdata   = AIoSpaceMosi & f_size_mask(AIoSpaceWrSize);
    assign w_pop_req = w_rd && w_is_data;
    assign w_flush   = w_wr && w_is_ctrl && w_wdata[CCtrlFlush];

    // Upper write-data lanes beyond CDataW are legitimately discarded.
    assign w_unused = ^w_wdata;

    ms_sync_fifo #(
        .CDepth (CDepth),
        .CDataW (CDataW)
    ) u_fifo (
        .clk         (AClkH),
        .rst_n       (AResetHN),
        .i_en        (AClkHEn),
        .i_push      (ALclWrEn),
        .i_data      (ALclData),
        .i_pop       (w_pop_req),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_fill      (w_fill),
        .o_empty_nxt (w_empty_nxt),
        .o_drop      (w_drop)
    );

    assign w_fill8 = 8'(w_fill);

    // Read data is driven only in the completion cycle so the shared OR bus
    // sees zero from this responder at all other times.
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            if (w_is_data) begin
                if (!w_empty) begin
                    w_rdata = 64'(w_head);
                end
            end else if (w_is_stat) begin
                w_rdata[CStatFillLsb +: 8] = w_fill8;
                w_rdata[CStatUnf]          = r_unf;
                w_rdata[CStatOvf]          = r_ovf;
                w_rdata[CStatFull]         = w_full;
                w_rdata[CStatEmpty]        = w_empty;
            end else if (w_is_ctrl) begin
                w_rdata[CCtrlIrqEn] = r_irq_en;
            end
        end
    end

    assign AIoSpaceMiso = w_rdata & f_size_mask(AIoSpaceRdSize);
    assign AIoSpaceBusy = w_busy;
    assign AIoSpaceSrq  = r_srq;
    assign ALclFull     = w_full;
    assign ATxData      = r_tx_data;
    assign ATxStrobe    = r_tx_strobe;

    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            r_wait      <= '0;
            r_irq_en    <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_tx_data   <= '0;
            r_tx_strobe <= 1'b0;
            r_srq       <= 1'b0;
        end else if (AClkHEn) begin
            // Any cycle without Busy (completion, or request withdrawn) restarts the wait.
            r_wait <= w_busy ? (r_wait + CWaitOne) : '0;

            if (w_wr && w_is_ctrl) begin
                r_irq_en <= w_wdata[CCtrlIrqEn];
            end

            // A new error event takes priority over a same-cycle clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_wr && w_is_stat && w_wdata[CStatOvf]) begin
                r_ovf <= 1'b0;
            end

            if (w_pop_req && w_empty) begin
                r_unf <= 1'b1;
            end else if (w_wr && w_is_stat && w_wdata[CStatUnf]) begin
                r_unf <= 1'b0;
            end

            r_tx_strobe <= w_wr && w_is_data;
            if (w_wr && w_is_data) begin
                r_tx_data <= w_wdata[CDataW-1:0];
            end

            r_srq <= r_irq_en & ~w_empty_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ms_io_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ms_io_mailbox
//  Purpose  : Self-checking bench for ms_io_mailbox. A queue model of the
//             FIFO produces expected read data, which is pushed to a
//             scoreboard when a read is issued and compared on completion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ms_io_mailbox;

    localparam logic [15:0] BASE = 16'h0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic [15:0] io_addr = '0;
    logic [63:0] io_mosi = '0;
    logic [63:0] io_miso;
    logic [3:0]  io_wsz = '0;
    logic [3:0]  io_rsz = '0;
    logic        io_busy;
    logic        io_srq;
    logic [31:0] lcl_data = '0;
    logic        lcl_wr = 1'b0;
    logic        lcl_full;
    logic [31:0] tx_data;
    logic        tx_strobe;

    always #5 clk = ~clk;

    ms_io_mailbox dut (
        .AClkH          (clk),
        .AResetHN       (rst_n),
        .AClkHEn        (clk_en),
        .AIoSpaceAddr   (io_addr),
        .AIoSpaceMosi   (io_mosi),
        .AIoSpaceMiso   (io_miso),
        .AIoSpaceWrSize (io_wsz),
        .AIoSpaceRdSize (io_rsz),
        .AIoSpaceBusy   (io_busy),
        .AIoSpaceSrq    (io_srq),
        .ALclData       (lcl_data),
        .ALclWrEn       (lcl_wr),
        .ALclFull       (lcl_full),
        .ATxData        (tx_data),
        .ATxStrobe      (tx_strobe)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mdl_q[$];
    bit          mdl_ovf = 1'b0;
    bit          mdl_unf = 1'b0;
    bit          mdl_irq = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] bmask(input logic [3:0] sz);
        case (sz)
            4'd1:    return 64'h0000_0000_0000_00FF;
            4'd2:    return 64'h0000_0000_0000_FFFF;
            4'd4:    return 64'h0000_0000_FFFF_FFFF;
            4'd8:    return {64{1'b1}};
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] mdl_stat();
        logic [63:0] s;
        s        = '0;
        s[15:8]  = 8'(mdl_q.size());
        s[3]     = mdl_unf;
        s[2]     = mdl_ovf;
        s[1]     = (mdl_q.size() == 8);
        s[0]     = (mdl_q.size() == 0);
        return s;
    endfunction

    function automatic void mdl_push(input logic [31:0] d);
        if (mdl_q.size() < 8) mdl_q.push_back(d);
        else                  mdl_ovf = 1'b1;
    endfunction

    // One bus access; waits out Busy, checks read data against the
    // scoreboard in the completion cycle, optionally pushes locally then.
    task automatic bus_xfer(input string tag, input logic [15:0] addr,
                            input logic [3:0] wsz, input logic [3:0] rsz,
                            input logic [63:0] wdata, input int exp_busy,
                            input bit lpush, input logic [31:0] ldata);
        int nb = 0;
        bit done = 1'b0;
        io_addr = addr; io_mosi = wdata; io_wsz = wsz; io_rsz = rsz;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (io_busy) begin
                nb++;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
                if (rsz != 4'd0) begin
                    if (exp_q.size() == 0) check({tag, "_noexp"}, 64'd1, 64'd0);
                    else                   check({tag, "_data"}, io_miso, exp_q.pop_front());
                end
                if (lpush) begin
                    lcl_data = ldata;
                    lcl_wr   = 1'b1;
                end
                @(posedge clk); #1;
                lcl_wr = 1'b0;
            end
        end
        if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
        check({tag, "_busy"}, 64'(nb), 64'(exp_busy));
        io_wsz = '0; io_rsz = '0;
    endtask

    task automatic rd_stat(input string tag, input logic [3:0] sz);
        exp_q.push_back(mdl_stat() & bmask(sz));
        bus_xfer(tag, BASE + 16'h8, 4'd0, sz, 64'd0, 0, 1'b0, 32'd0);
    endtask

    task automatic rd_ctrl(input string tag);
        exp_q.push_back({63'd0, mdl_irq});
        bus_xfer(tag, BASE + 16'h10, 4'd0, 4'd8, 64'd0, 0, 1'b0, 32'd0);
    endtask

    task automatic rd_data(input string tag, input logic [3:0] sz, input bit lpush, input logic [31:0] ldata);
        if (mdl_q.size() == 0) begin
            mdl_unf = 1'b1;
            exp_q.push_back(64'd0);
        end else begin
            exp_q.push_back({32'd0, mdl_q.pop_front()} & bmask(sz));
        end
        if (lpush) mdl_push(ldata);
        bus_xfer(tag, BASE, 4'd0, sz, 64'd0, 2, lpush, ldata);
    endtask

    task automatic lcl_push(input logic [31:0] d);
        lcl_data = d;
        lcl_wr   = 1'b1;
        @(posedge clk); #1;
        lcl_wr   = 1'b0;
        mdl_push(d);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_full", 64'(lcl_full), 64'd0);
        check("rst_srq", 64'(io_srq), 64'd0);
        check("rst_strobe", 64'(tx_strobe), 64'd0);
        check("rst_txdata", 64'(tx_data), 64'd0);
        check("rst_busy", 64'(io_busy), 64'd0);
        check("rst_miso", io_miso, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_stat("rst_stat", 4'd4);

        // 1: single word through the mailbox
        lcl_push(32'hDEAD_BEEF);
        rd_data("t1_pop", 4'd4, 1'b0, 32'd0);
        rd_stat("t1_stat", 4'd4);

        // Unselected / misaligned addresses
        io_addr = BASE + 16'h4; io_rsz = 4'd8;
        @(negedge clk);
        check("unsel_mis_busy", 64'(io_busy), 64'd0);
        check("unsel_mis_miso", io_miso, 64'd0);
        io_addr = 16'h0200; io_wsz = 4'd8; io_rsz = 4'd0; io_mosi = '1;
        @(negedge clk);
        check("unsel_far_busy", 64'(io_busy), 64'd0);
        @(posedge clk); #1;
        check("unsel_far_strobe", 64'(tx_strobe), 64'd0);
        io_wsz = 4'd0;

        // Clock enable low: a push must not land
        clk_en = 1'b0; lcl_data = 32'h5555_5555; lcl_wr = 1'b1;
        @(posedge clk); #1;
        lcl_wr = 1'b0; clk_en = 1'b1;
        rd_stat("clken_stat", 4'd4);

        // 2: overflow
        for (int i = 0; i < 9; i++) lcl_push(32'h1000_0000 + 32'(i));
        @(negedge clk);
        check("t2_full", 64'(lcl_full), 64'd1);
        rd_stat("t2_stat_ovf", 4'd4);
        bus_xfer("t2_clr_ovf", BASE + 16'h8, 4'd4, 4'd0, 64'h4, 0, 1'b0, 32'd0);
        mdl_ovf = 1'b0;
        rd_stat("t2_stat_clr", 4'd4);
        rd_stat("t2_stat_b1", 4'd1);

        // 4: pop from full with a simultaneous local push
        rd_data("t4_pop_full", 4'd4, 1'b1, 32'hA5A5_0008);
        rd_stat("t4_stat", 4'd4);
        for (int i = 0; i < 8; i++) rd_data("t4_drain", 4'd4, 1'b0, 32'd0);

        // Simultaneous push and pop while empty
        rd_data("emp_pop_push", 4'd4, 1'b1, 32'h0BAD_F00D);
        rd_stat("emp_stat", 4'd4);
        bus_xfer("emp_clr_unf", BASE + 16'h8, 4'd4, 4'd0, 64'h8, 0, 1'b0, 32'd0);
        mdl_unf = 1'b0;
        rd_data("emp_drain", 4'd8, 1'b0, 32'd0);

        // 3: narrow read and underflow
        lcl_push(32'h1122_3344);
        rd_data("t3_b1", 4'd1, 1'b0, 32'd0);
        rd_data("t3_unf", 4'd4, 1'b0, 32'd0);
        rd_stat("t3_stat", 4'd4);
        bus_xfer("t3_clr_unf", BASE + 16'h8, 4'd4, 4'd0, 64'h8, 0, 1'b0, 32'd0);
        mdl_unf = 1'b0;

        // 5: interrupt enable, Srq timing, flush
        bus_xfer("t5_irq_on", BASE + 16'h10, 4'd4, 4'd0, 64'h1, 0, 1'b0, 32'd0);
        mdl_irq = 1'b1;
        lcl_data = 32'hCAFE_0001; lcl_wr = 1'b1;
        @(negedge clk);
        check("t5_srq_before", 64'(io_srq), 64'd0);
        @(posedge clk); #1;
        lcl_wr = 1'b0;
        mdl_push(32'hCAFE_0001);
        check("t5_srq_after", 64'(io_srq), 64'd1);
        bus_xfer("t5_flush", BASE + 16'h10, 4'd4, 4'd0, 64'h3, 0, 1'b0, 32'd0);
        mdl_q.delete();
        check("t5_srq_flush", 64'(io_srq), 64'd0);
        rd_stat("t5_stat", 4'd4);
        rd_ctrl("t5_ctrl");

        // 6: outbound write with byte masking
        check("t6_strobe_pre", 64'(tx_strobe), 64'd0);
        bus_xfer("t6_wr", BASE, 4'd2, 4'd0, 64'hFFFF_FFFF_FFFF_ABCD, 2, 1'b0, 32'd0);
        check("t6_strobe", 64'(tx_strobe), 64'd1);
        check("t6_txdata", 64'(tx_data), 64'h0000_ABCD);
        @(posedge clk); #1;
        check("t6_strobe_end", 64'(tx_strobe), 64'd0);
        check("t6_txdata_hold", 64'(tx_data), 64'h0000_ABCD);

        // Asynchronous reset with a full FIFO and Srq asserted
        for (int i = 0; i < 8; i++) lcl_push(32'h2000_0000 + 32'(i));
        @(negedge clk);
        check("ar_full_pre", 64'(lcl_full), 64'd1);
        check("ar_srq_pre", 64'(io_srq), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_full", 64'(lcl_full), 64'd0);
        check("ar_srq", 64'(io_srq), 64'd0);
        check("ar_txdata", 64'(tx_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_q.delete(); mdl_ovf = 1'b0; mdl_unf = 1'b0; mdl_irq = 1'b0;
        @(posedge clk); #1;
        rd_stat("ar_stat", 4'd4);
        rd_ctrl("ar_ctrl");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
